// File: rtl/tick_scheduler_pkg.sv
// Shared types and widths for the tick scheduler and its level tracker.
package tick_scheduler_pkg;

  localparam int LEVEL_W = 4;
  localparam int FCNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/tick_scheduler_level_tracker.sv
// Apple counter and speed level; derives the frames-per-tick period from the level.
module level_tracker
  import tick_scheduler_pkg::*;
#(
  parameter int FRAMES_START     = 30,
  parameter int FRAMES_MIN       = 6,
  parameter int FRAMES_STEP      = 2,
  parameter int APPLES_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_eat,
  input  logic               i_clear,
  output logic [LEVEL_W-1:0] o_level,
  output logic [FCNT_W-1:0]  o_period
);

  localparam logic [3:0]  APPLE_LAST = 4'(APPLES_PER_LEVEL - 1);
  localparam logic [11:0] START_W    = 12'(FRAMES_START);
  localparam logic [11:0] MIN_W      = 12'(FRAMES_MIN);
  localparam logic [11:0] STEP_W     = 12'(FRAMES_STEP);

  logic [3:0]         apple_cnt_q, apple_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [11:0]        drop, diff, period_w;

  // Next apple count / level: clear wins, level saturates at its maximum.
  always_comb begin
    apple_cnt_d = apple_cnt_q;
    level_d     = level_q;
    if (i_clear) begin
      apple_cnt_d = '0;
      level_d     = '0;
    end else if (i_eat) begin
      if (apple_cnt_q == APPLE_LAST) begin
        apple_cnt_d = '0;
        if (level_q != '1) level_d = level_q + LEVEL_W'(1);
      end else begin
        apple_cnt_d = apple_cnt_q + 4'd1;
      end
    end
  end

  // Apple count and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apple_cnt_q <= '0;
      level_q     <= '0;
    end else begin
      apple_cnt_q <= apple_cnt_d;
      level_q     <= level_d;
    end
  end

  // Period = max(start - level*step, min), guarded against underflow in 12 bits.
  always_comb begin
    drop     = 12'(level_q) * STEP_W;
    diff     = '0;
    period_w = MIN_W;
    if (drop < START_W) begin
      diff = START_W - drop;
      if (diff > MIN_W) period_w = diff;
    end
  end

  assign o_level  = level_q;
  assign o_period = period_w[FCNT_W-1:0];

endmodule

// File: rtl/tick_scheduler.sv
// Game-pace controller: converts frame pulses into tick-phase toggles, handles
// pause, and holds the game-over screen before issuing an auto-restart pulse.
//
// state | meaning
// IDLE  | waiting for start; frame counter preloaded, level cleared
// RUN   | counting frames, toggling phase every period
// PAUSE | frame counter frozen until the next pause toggle
// OVER  | end-of-game hold, counting frames down to auto restart
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int FRAMES_START     = 30,
  parameter int FRAMES_MIN       = 6,
  parameter int FRAMES_STEP      = 2,
  parameter int APPLES_PER_LEVEL = 4,
  parameter int OVER_FRAMES      = 180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame,
  input  logic               i_start,
  input  logic               i_eat,
  input  logic               i_failure,
  input  logic               i_success,
  input  logic               i_pause,
  input  logic               i_restart,
  output logic               o_phase,
  output logic               o_restart,
  output logic [LEVEL_W-1:0] o_level,
  output logic [1:0]         o_state
);

  sched_state_t      state_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic [FCNT_W-1:0] over_cnt_q;
  logic              phase_q;
  logic              restart_q;
  logic [FCNT_W-1:0] period;
  logic              over_done;
  logic              lvl_eat;
  logic              lvl_clear;

  assign over_done = (state_q == OVER) && i_frame && (over_cnt_q == FCNT_W'(1));
  assign lvl_eat   = i_eat && ((state_q == RUN) || (state_q == PAUSE));
  assign lvl_clear = i_restart || (state_q == IDLE) || over_done;

  level_tracker #(
    .FRAMES_START     (FRAMES_START),
    .FRAMES_MIN       (FRAMES_MIN),
    .FRAMES_STEP      (FRAMES_STEP),
    .APPLES_PER_LEVEL (APPLES_PER_LEVEL)
  ) u_level (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_eat    (lvl_eat),
    .i_clear  (lvl_clear),
    .o_level  (o_level),
    .o_period (period)
  );

  // Scheduler FSM with frame/over counters and registered phase/restart outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= FCNT_W'(FRAMES_START);
      over_cnt_q  <= '0;
      phase_q     <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      if (i_restart) begin
        // Phase deliberately kept so the game core sees no spurious tick.
        state_q     <= IDLE;
        frame_cnt_q <= FCNT_W'(FRAMES_START);
        over_cnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            frame_cnt_q <= period;
            if (i_start) state_q <= RUN;
          end
          RUN: begin
            if (i_failure || i_success) begin
              state_q    <= OVER;
              over_cnt_q <= FCNT_W'(OVER_FRAMES);
            end else if (i_pause) begin
              state_q <= PAUSE;
            end else if (i_frame) begin
              if (frame_cnt_q == FCNT_W'(1)) begin
                phase_q     <= ~phase_q;
                frame_cnt_q <= period;
              end else begin
                frame_cnt_q <= frame_cnt_q - FCNT_W'(1);
              end
            end
          end
          PAUSE: begin
            if (i_failure || i_success) begin
              state_q    <= OVER;
              over_cnt_q <= FCNT_W'(OVER_FRAMES);
            end else if (i_pause) begin
              state_q <= RUN;
            end
          end
          OVER: begin
            if (i_frame) begin
              over_cnt_q <= over_cnt_q - FCNT_W'(1);
              if (over_done) begin
                state_q   <= IDLE;
                restart_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_phase   = phase_q;
  assign o_restart = restart_q;
  assign o_state   = state_q;

endmodule
